// File: rtl/cc_frogger_pkg.sv
// Shared Frogger definitions: game-state encoding plus the default level, lives,
// speed and pause constants used by the level sequencer, comparator and lanes.
package cc_frogger_pkg;

    localparam int CC_LEVELS_DATAWIDTH = 5;
    localparam int CC_MAX_LEVEL        = 5;
    localparam int CC_INIT_LIVES       = 3;
    localparam int CC_LIVES_DATAWIDTH  = 3;
    localparam int CC_PAUSE_CYCLES     = 50000000;
    localparam int CC_SPEED_DATAWIDTH  = 26;
    localparam int CC_BASE_SPEED       = 25000000;
    localparam int CC_SPEED_STEP       = 4000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_LVL_PAUSE,
        ST_DIE_PAUSE,
        ST_WIN,
        ST_GAME_OVER
    } state_t;

endpackage

// File: rtl/cc_level_sequencer_if.sv
// Level-sequencer bus: detector inputs (start/goal/collision) and the level,
// lives, speed and play-control outputs towards the lane/sprite datapath.
interface cc_level_sequencer_if
    import cc_frogger_pkg::*;
#(
    parameter int LEVELS_DATAWIDTH = CC_LEVELS_DATAWIDTH,
    parameter int LIVES_DATAWIDTH  = CC_LIVES_DATAWIDTH,
    parameter int SPEED_DATAWIDTH  = CC_SPEED_DATAWIDTH
);

    logic                        CC_LEVEL_SEQUENCER_start_InLow;
    logic                        CC_LEVEL_SEQUENCER_goal_InHigh;
    logic                        CC_LEVEL_SEQUENCER_collision_InHigh;
    logic [LEVELS_DATAWIDTH-1:0] CC_LEVEL_SEQUENCER_level_Out;
    logic [LIVES_DATAWIDTH-1:0]  CC_LEVEL_SEQUENCER_lives_Out;
    logic [SPEED_DATAWIDTH-1:0]  CC_LEVEL_SEQUENCER_speed_Out;
    logic                        CC_LEVEL_SEQUENCER_load_OutHigh;
    logic                        CC_LEVEL_SEQUENCER_play_OutHigh;
    logic                        CC_LEVEL_SEQUENCER_win_OutHigh;
    logic                        CC_LEVEL_SEQUENCER_gameover_OutHigh;

    // master is the detector side, slave is the sequencer itself
    modport master (
        output CC_LEVEL_SEQUENCER_start_InLow,
        output CC_LEVEL_SEQUENCER_goal_InHigh,
        output CC_LEVEL_SEQUENCER_collision_InHigh,
        input  CC_LEVEL_SEQUENCER_level_Out,
        input  CC_LEVEL_SEQUENCER_lives_Out,
        input  CC_LEVEL_SEQUENCER_speed_Out,
        input  CC_LEVEL_SEQUENCER_load_OutHigh,
        input  CC_LEVEL_SEQUENCER_play_OutHigh,
        input  CC_LEVEL_SEQUENCER_win_OutHigh,
        input  CC_LEVEL_SEQUENCER_gameover_OutHigh
    );

    modport slave (
        input  CC_LEVEL_SEQUENCER_start_InLow,
        input  CC_LEVEL_SEQUENCER_goal_InHigh,
        input  CC_LEVEL_SEQUENCER_collision_InHigh,
        output CC_LEVEL_SEQUENCER_level_Out,
        output CC_LEVEL_SEQUENCER_lives_Out,
        output CC_LEVEL_SEQUENCER_speed_Out,
        output CC_LEVEL_SEQUENCER_load_OutHigh,
        output CC_LEVEL_SEQUENCER_play_OutHigh,
        output CC_LEVEL_SEQUENCER_win_OutHigh,
        output CC_LEVEL_SEQUENCER_gameover_OutHigh
    );

endinterface

// File: rtl/cc_level_speed_rom.sv
// Combinational level -> lane prescaler map: BASE_SPEED - (level-1)*SPEED_STEP,
// floored at SPEED_STEP so faster levels never wrap to a huge compare value.
module cc_level_speed_rom
    import cc_frogger_pkg::*;
#(
    parameter int LEVELS_DATAWIDTH = CC_LEVELS_DATAWIDTH,
    parameter int SPEED_DATAWIDTH  = CC_SPEED_DATAWIDTH,
    parameter int BASE_SPEED       = CC_BASE_SPEED,
    parameter int SPEED_STEP       = CC_SPEED_STEP
) (
    input  logic [LEVELS_DATAWIDTH-1:0] i_level,
    output logic [SPEED_DATAWIDTH-1:0]  o_speed
);

    localparam int CW = SPEED_DATAWIDTH + LEVELS_DATAWIDTH + 1;

    logic [CW-1:0] w_steps;
    logic [CW-1:0] w_offset;
    logic [CW-1:0] w_floor;

    // level 0 (idle) maps like level 1 so the preset stays at BASE_SPEED
    always_comb begin
        w_steps = '0;
        if (i_level != '0) begin
            w_steps = CW'(i_level) - CW'(1);
        end
        w_offset = w_steps * CW'(SPEED_STEP);
        w_floor  = w_offset + CW'(SPEED_STEP);
        if (w_floor > CW'(BASE_SPEED)) begin
            o_speed = SPEED_DATAWIDTH'(SPEED_STEP);
        end else begin
            o_speed = SPEED_DATAWIDTH'(CW'(BASE_SPEED) - w_offset);
        end
    end

endmodule

// File: rtl/cc_level_sequencer.sv
// Frogger level sequencer: level/lives bookkeeping, pauses, WIN and GAME OVER.
// Optional build macro CC_LEVEL_SEQUENCER_EXTRA_LIFE_EN grants a life per cleared level.
module cc_level_sequencer
    import cc_frogger_pkg::*;
#(
    parameter int LEVELS_DATAWIDTH = CC_LEVELS_DATAWIDTH,
    parameter int MAX_LEVEL        = CC_MAX_LEVEL,
    parameter int INIT_LIVES       = CC_INIT_LIVES,
    parameter int LIVES_DATAWIDTH  = CC_LIVES_DATAWIDTH,
    parameter int PAUSE_CYCLES     = CC_PAUSE_CYCLES,
    parameter int SPEED_DATAWIDTH  = CC_SPEED_DATAWIDTH,
    parameter int BASE_SPEED       = CC_BASE_SPEED,
    parameter int SPEED_STEP       = CC_SPEED_STEP
) (
    input logic                 CC_LEVEL_SEQUENCER_CLOCK_50,
    input logic                 CC_LEVEL_SEQUENCER_RESET_InLow,
    cc_level_sequencer_if.slave bus
);

    localparam int PCW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [PCW-1:0]              LP_PAUSE_LAST = PCW'(PAUSE_CYCLES - 1);
    localparam logic [LEVELS_DATAWIDTH-1:0] LP_MAX_LEVEL  = LEVELS_DATAWIDTH'(MAX_LEVEL);

    logic                        r_startQ, r_startQ2;
    logic                        r_goalQ, r_goalQ2;
    logic                        r_colQ, r_colQ2;
    state_t                      r_state;
    logic [LEVELS_DATAWIDTH-1:0] r_level;
    logic [LIVES_DATAWIDTH-1:0]  r_lives;
    logic [SPEED_DATAWIDTH-1:0]  r_speed;
    logic [PCW-1:0]              r_pauseCnt;
    logic                        r_load, r_play, r_win, r_gameover;

    logic                        w_startEv, w_goalEv, w_colEv;
    logic                        w_pauseDone;
    logic [LIVES_DATAWIDTH-1:0]  w_livesMinus;
    logic [SPEED_DATAWIDTH-1:0]  w_romSpeed;

    cc_level_speed_rom #(
        .LEVELS_DATAWIDTH (LEVELS_DATAWIDTH),
        .SPEED_DATAWIDTH  (SPEED_DATAWIDTH),
        .BASE_SPEED       (BASE_SPEED),
        .SPEED_STEP       (SPEED_STEP)
    ) u_speed_rom (
        .i_level (r_level),
        .o_speed (w_romSpeed)
    );

    // start is active-low, so its synchronised copy is inverted to make press a rising edge
    always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50 or negedge CC_LEVEL_SEQUENCER_RESET_InLow) begin
        if (!CC_LEVEL_SEQUENCER_RESET_InLow) begin
            r_startQ  <= 1'b0;
            r_startQ2 <= 1'b0;
            r_goalQ   <= 1'b0;
            r_goalQ2  <= 1'b0;
            r_colQ    <= 1'b0;
            r_colQ2   <= 1'b0;
        end else begin
            r_startQ  <= ~bus.CC_LEVEL_SEQUENCER_start_InLow;
            r_startQ2 <= r_startQ;
            r_goalQ   <= bus.CC_LEVEL_SEQUENCER_goal_InHigh;
            r_goalQ2  <= r_goalQ;
            r_colQ    <= bus.CC_LEVEL_SEQUENCER_collision_InHigh;
            r_colQ2   <= r_colQ;
        end
    end

    assign w_startEv    = r_startQ & ~r_startQ2;
    assign w_goalEv     = r_goalQ & ~r_goalQ2;
    assign w_colEv      = r_colQ & ~r_colQ2;
    assign w_pauseDone  = (r_pauseCnt == LP_PAUSE_LAST);
    assign w_livesMinus = (r_lives == '0) ? '0 : r_lives - LIVES_DATAWIDTH'(1);

`ifdef CC_LEVEL_SEQUENCER_EXTRA_LIFE_EN
    logic [LIVES_DATAWIDTH-1:0] w_livesPlus;
    assign w_livesPlus = (r_lives == '1) ? r_lives : r_lives + LIVES_DATAWIDTH'(1);
`endif

    always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50 or negedge CC_LEVEL_SEQUENCER_RESET_InLow) begin
        if (!CC_LEVEL_SEQUENCER_RESET_InLow) begin
            r_state    <= ST_IDLE;
            r_level    <= '0;
            r_lives    <= '0;
            r_speed    <= SPEED_DATAWIDTH'(BASE_SPEED);
            r_pauseCnt <= '0;
            r_load     <= 1'b0;
            r_play     <= 1'b0;
            r_win      <= 1'b0;
            r_gameover <= 1'b0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_startEv) begin
                        r_state <= ST_LOAD;
                        r_level <= LEVELS_DATAWIDTH'(1);
                        r_lives <= LIVES_DATAWIDTH'(INIT_LIVES);
                        r_load  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_speed <= w_romSpeed;
                    r_play  <= 1'b1;
                    r_state <= ST_PLAY;
                end
                // goal takes priority over a same-cycle collision
                ST_PLAY: begin
                    if (w_goalEv) begin
                        r_play <= 1'b0;
                        if (r_level >= LP_MAX_LEVEL) begin
                            r_state <= ST_WIN;
                            r_win   <= 1'b1;
                        end else begin
                            r_state    <= ST_LVL_PAUSE;
                            r_pauseCnt <= '0;
`ifdef CC_LEVEL_SEQUENCER_EXTRA_LIFE_EN
                            r_lives    <= w_livesPlus;
`endif
                        end
                    end else if (w_colEv) begin
                        r_play  <= 1'b0;
                        r_lives <= w_livesMinus;
                        if (w_livesMinus == '0) begin
                            r_state    <= ST_GAME_OVER;
                            r_gameover <= 1'b1;
                        end else begin
                            r_state    <= ST_DIE_PAUSE;
                            r_pauseCnt <= '0;
                        end
                    end
                end
                ST_LVL_PAUSE: begin
                    if (w_pauseDone) begin
                        r_state <= ST_LOAD;
                        r_load  <= 1'b1;
                        if (r_level < LP_MAX_LEVEL) begin
                            r_level <= r_level + LEVELS_DATAWIDTH'(1);
                        end
                    end else begin
                        r_pauseCnt <= r_pauseCnt + PCW'(1);
                    end
                end
                ST_DIE_PAUSE: begin
                    if (w_pauseDone) begin
                        r_state <= ST_LOAD;
                        r_load  <= 1'b1;
                    end else begin
                        r_pauseCnt <= r_pauseCnt + PCW'(1);
                    end
                end
                ST_WIN, ST_GAME_OVER: begin
                    if (w_startEv) begin
                        r_state    <= ST_IDLE;
                        r_level    <= '0;
                        r_win      <= 1'b0;
                        r_gameover <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.CC_LEVEL_SEQUENCER_level_Out        = r_level;
    assign bus.CC_LEVEL_SEQUENCER_lives_Out        = r_lives;
    assign bus.CC_LEVEL_SEQUENCER_speed_Out        = r_speed;
    assign bus.CC_LEVEL_SEQUENCER_load_OutHigh     = r_load;
    assign bus.CC_LEVEL_SEQUENCER_play_OutHigh     = r_play;
    assign bus.CC_LEVEL_SEQUENCER_win_OutHigh      = r_win;
    assign bus.CC_LEVEL_SEQUENCER_gameover_OutHigh = r_gameover;

endmodule

// File: tb/tb_cc_level_sequencer.sv
// Directed bench for cc_level_sequencer: two instances with PAUSE_CYCLES=4, one with
// default speeds and one with BASE_SPEED=10/SPEED_STEP=4 to exercise speed saturation.
module tb_cc_level_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int nCompared   = 0;
    int nMismatched = 0;
    int expLives    = 0;

`ifdef CC_LEVEL_SEQUENCER_EXTRA_LIFE_EN
    localparam bit EXTRA = 1'b1;
`else
    localparam bit EXTRA = 1'b0;
`endif

    int speedA [5] = '{25000000, 21000000, 17000000, 13000000, 9000000};
    int speedB [5] = '{10, 6, 4, 4, 4};

    always #5 clk = ~clk;

    cc_level_sequencer_if busA ();
    cc_level_sequencer_if busB ();

    cc_level_sequencer #(
        .PAUSE_CYCLES (4)
    ) dutA (
        .CC_LEVEL_SEQUENCER_CLOCK_50    (clk),
        .CC_LEVEL_SEQUENCER_RESET_InLow (rst_n),
        .bus                            (busA)
    );

    cc_level_sequencer #(
        .PAUSE_CYCLES (4),
        .BASE_SPEED   (10),
        .SPEED_STEP   (4)
    ) dutB (
        .CC_LEVEL_SEQUENCER_CLOCK_50    (clk),
        .CC_LEVEL_SEQUENCER_RESET_InLow (rst_n),
        .bus                            (busB)
    );

    // Both instances see identical stimulus; inputs change on the falling edge.
    task automatic applyStimulus(input logic startN, input logic goal, input logic col, input int cycles);
        busA.CC_LEVEL_SEQUENCER_start_InLow     = startN;
        busA.CC_LEVEL_SEQUENCER_goal_InHigh     = goal;
        busA.CC_LEVEL_SEQUENCER_collision_InHigh = col;
        busB.CC_LEVEL_SEQUENCER_start_InLow     = startN;
        busB.CC_LEVEL_SEQUENCER_goal_InHigh     = goal;
        busB.CC_LEVEL_SEQUENCER_collision_InHigh = col;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkDut(input string tag, input int lvl, input int lives, input int load,
                            input int play, input int win, input int go);
        checkOutput({tag, ".level"}, 32'(busA.CC_LEVEL_SEQUENCER_level_Out), lvl);
        checkOutput({tag, ".lives"}, 32'(busA.CC_LEVEL_SEQUENCER_lives_Out), lives);
        checkOutput({tag, ".load"}, 32'(busA.CC_LEVEL_SEQUENCER_load_OutHigh), load);
        checkOutput({tag, ".play"}, 32'(busA.CC_LEVEL_SEQUENCER_play_OutHigh), play);
        checkOutput({tag, ".win"}, 32'(busA.CC_LEVEL_SEQUENCER_win_OutHigh), win);
        checkOutput({tag, ".gameover"}, 32'(busA.CC_LEVEL_SEQUENCER_gameover_OutHigh), go);
    endtask

    task automatic checkSpeed(input string tag, input int expA, input int expB);
        checkOutput({tag, ".speedA"}, 32'(busA.CC_LEVEL_SEQUENCER_speed_Out), expA);
        checkOutput({tag, ".speedB"}, 32'(busB.CC_LEVEL_SEQUENCER_speed_Out), expB);
    endtask

    function automatic int livesAfterClear(input int l);
        return (EXTRA && l < 7) ? l + 1 : l;
    endfunction

    // Start press from IDLE: LOAD two clocks later, PLAY one clock after that.
    task automatic startGame(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        expLives = 3;
        checkDut({tag, ".load"}, 1, 3, 1, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkDut({tag, ".play"}, 1, 3, 0, 1, 0, 0);
        checkSpeed({tag, ".lvl1"}, speedA[0], speedB[0]);
    endtask

    // One-clock goal pulse at level lvl (< 5): 4 pause clocks, load pulse, then PLAY at lvl+1.
    task automatic clearLevel(input int lvl);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        expLives = livesAfterClear(expLives);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) applyStimulus(1'b1, 1'b0, 1'b0, 1);
            checkDut($sformatf("lvlPause%0d_%0d", lvl, i), lvl, expLives, 0, 0, 0, 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkDut($sformatf("reload%0d", lvl + 1), lvl + 1, expLives, 1, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkDut($sformatf("play%0d", lvl + 1), lvl + 1, expLives, 0, 1, 0, 0);
        checkSpeed($sformatf("lvl%0d", lvl + 1), speedA[lvl], speedB[lvl]);
    endtask

    // One-clock collision pulse: DIE_PAUSE and reload at same level, or GAME_OVER on last life.
    task automatic loseLife(input int lvl);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        expLives = expLives - 1;
        if (expLives == 0) begin
            checkDut("gameOver", lvl, 0, 0, 0, 0, 1);
        end else begin
            checkDut($sformatf("diePause%0d", expLives), lvl, expLives, 0, 0, 0, 0);
            applyStimulus(1'b1, 1'b0, 1'b0, 4);
            checkDut($sformatf("dieReload%0d", expLives), lvl, expLives, 1, 0, 0, 0);
            applyStimulus(1'b1, 1'b0, 1'b0, 1);
            checkDut($sformatf("diePlay%0d", expLives), lvl, expLives, 0, 1, 0, 0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        checkDut("reset", 0, 0, 0, 0, 0, 0);
        checkSpeed("reset", 25000000, 10);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 2);
        checkDut("idle", 0, 0, 0, 0, 0, 0);

        // Game 1: clear level 1, then die until GAME_OVER at level 2
        startGame("game1");
        clearLevel(1);
        while (expLives > 0) loseLife(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        checkDut("goIgnoreGoal", 2, 0, 0, 0, 0, 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        checkDut("goIgnoreCol", 2, 0, 0, 0, 0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkDut("goToIdle", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);

        // Game 2: climb to level 5 with a held goal, then goal+collision together -> WIN
        startGame("game2");
        for (int l = 1; l <= 3; l++) clearLevel(l);
        applyStimulus(1'b1, 1'b1, 1'b0, 2);
        expLives = livesAfterClear(expLives);
        checkDut("heldPause", 4, expLives, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4);
        checkDut("heldReload", 5, expLives, 1, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkSpeed("lvl5", speedA[4], speedB[4]);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1);
            checkDut($sformatf("heldNoRetrig%0d", i), 5, expLives, 0, 1, 0, 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 2);
        checkDut("heldRelease", 5, expLives, 0, 1, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkDut("win", 5, expLives, 0, 0, 1, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        checkDut("winIgnoreCol", 5, expLives, 0, 0, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkDut("winToIdle", 0, expLives, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);

        // Game 3: asynchronous reset in the middle of the level-3 pause
        startGame("game3");
        clearLevel(1);
        clearLevel(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 2);
        checkDut("prePauseReset", 3, livesAfterClear(expLives), 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkDut("asyncReset", 0, 0, 0, 0, 0, 0);
        checkSpeed("asyncReset", 25000000, 10);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 6);
        checkDut("afterReset", 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
